geom_seq_ctrl: RTL and testbench

//   Sequencer for the 8-bit geometric-progression datapath register.
//   On start, clears the value, loads 1 after one interval, then multiplies by

---
 rtl/geom_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_geom_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/geom_seq_ctrl.sv
// Sequencer for the geometric-progression value register: clear, load 1, then
// multiply by FACTOR once per INTERVAL cycles for STEPS steps, then end the run.
module geom_seq_ctrl #(
    parameter int WIDTH    = 8,
    parameter int INTERVAL = 100,
    parameter int STEPS    = 6,
    parameter int FACTOR   = 3,
    parameter int SW       = (STEPS > 0) ? $clog2(STEPS + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] value,
    output logic             value_valid,
    output logic [SW-1:0]    step_idx,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int PW = WIDTH + 32;
    localparam logic [CW-1:0] RELOAD = CW'(INTERVAL - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MUL, TAIL, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic              valid_q, valid_d;
    logic [SW-1:0]     step_q, step_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [PW-1:0]     prod;
    logic              tick;

    // Product kept wide so any carry out of the value width flags overflow.
    assign prod = PW'(value_q) * PW'(FACTOR);
    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = 1'b0;
        step_d  = step_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    value_d = '0;
                    valid_d = 1'b1;
                    ovf_d   = 1'b0;
                    step_d  = '0;
                    busy_d  = 1'b1;
                    cnt_d   = RELOAD;
                    state_d = LOAD;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = RELOAD;
                    case (state_q)
                        LOAD: begin
                            value_d = WIDTH'(1);
                            valid_d = 1'b1;
                            state_d = (STEPS == 0) ? TAIL : MUL;
                        end
                        MUL: begin
                            value_d = prod[WIDTH-1:0];
                            valid_d = 1'b1;
                            step_d  = step_q + 1'b1;
                            if (|prod[PW-1:WIDTH]) ovf_d = 1'b1;
                            if (step_d == SW'(STEPS)) state_d = TAIL;
                        end
                        TAIL: begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = DONE;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign step_idx    = step_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_geom_seq_ctrl.sv
// Bench for geom_seq_ctrl: three configurations checked every cycle against a
// schedule-based model, plus directed literal checks of the documented timelines.
module tb_geom_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_r [3];
    logic abort_r [3];
    logic chk_en = 1'b0;

    logic [7:0] val0, val1, val2;
    logic [2:0] st0;
    logic [1:0] st1;
    logic [2:0] st2;
    logic vv0, vv1, vv2, b0, b1, b2, d0, d1, d2, o0, o1, o2;

    int n_chk = 0;
    int n_pass = 0;

    localparam int P_INT [3]   = '{100, 1, 100};
    localparam int P_STEPS [3] = '{6, 2, 4};

    geom_seq_ctrl #(.WIDTH(8), .INTERVAL(100), .STEPS(6), .FACTOR(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .abort(abort_r[0]),
        .value(val0), .value_valid(vv0), .step_idx(st0), .busy(b0), .done(d0), .overflow(o0));
    geom_seq_ctrl #(.WIDTH(8), .INTERVAL(1), .STEPS(2), .FACTOR(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .abort(abort_r[1]),
        .value(val1), .value_valid(vv1), .step_idx(st1), .busy(b1), .done(d1), .overflow(o1));
    geom_seq_ctrl #(.WIDTH(8), .INTERVAL(100), .STEPS(4), .FACTOR(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_r[2]), .abort(abort_r[2]),
        .value(val2), .value_valid(vv2), .step_idx(st2), .busy(b2), .done(d2), .overflow(o2));

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Model: a run is described by its start cycle; every action is derived from
    // the elapsed cycles since that start divided by INTERVAL.
    longint cyc = 0;
    longint e0 [3] = '{0, 0, 0};
    bit     act [3] = '{0, 0, 0};
    bit     in_done [3] = '{0, 0, 0};
    int m_val [3] = '{0, 0, 0};
    int m_vv [3] = '{0, 0, 0};
    int m_step [3] = '{0, 0, 0};
    int m_busy [3] = '{0, 0, 0};
    int m_done [3] = '{0, 0, 0};
    int m_ovf [3] = '{0, 0, 0};

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                act[i] = 0; in_done[i] = 0; m_val[i] = 0; m_vv[i] = 0;
                m_step[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_ovf[i] = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 3; i++) begin
                m_vv[i] = 0;
                m_done[i] = 0;
                if (in_done[i]) begin
                    in_done[i] = 0;
                end else if (act[i]) begin
                    if (abort_r[i]) begin
                        act[i] = 0;
                        m_busy[i] = 0;
                    end else if ((cyc - e0[i]) % P_INT[i] == 0) begin
                        longint k;
                        k = (cyc - e0[i]) / P_INT[i];
                        if (k == 1) begin
                            m_val[i] = 1;
                            m_vv[i] = 1;
                        end else if (k <= P_STEPS[i] + 1) begin
                            int p;
                            p = m_val[i] * 3;
                            if (p > 255) m_ovf[i] = 1;
                            m_val[i] = p % 256;
                            m_step[i] = int'(k) - 1;
                            m_vv[i] = 1;
                        end else begin
                            m_done[i] = 1;
                            m_busy[i] = 0;
                            act[i] = 0;
                            in_done[i] = 1;
                        end
                    end
                end else if (start_r[i] && !abort_r[i]) begin
                    e0[i] = cyc;
                    act[i] = 1;
                    m_busy[i] = 1;
                    m_val[i] = 0;
                    m_vv[i] = 1;
                    m_step[i] = 0;
                    m_ovf[i] = 0;
                end
            end
        end
    end

    task automatic cmp(input int i, input int v, input int vv, input int st,
                       input int b, input int d, input int o);
        chk($sformatf("d%0d_value", i), v, m_val[i]);
        chk($sformatf("d%0d_valid", i), vv, m_vv[i]);
        chk($sformatf("d%0d_step", i), st, m_step[i]);
        chk($sformatf("d%0d_busy", i), b, m_busy[i]);
        chk($sformatf("d%0d_done", i), d, m_done[i]);
        chk($sformatf("d%0d_ovf", i), o, m_ovf[i]);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp(0, int'(val0), int'(vv0), int'(st0), int'(b0), int'(d0), int'(o0));
            cmp(1, int'(val1), int'(vv1), int'(st1), int'(b1), int'(d1), int'(o1));
            cmp(2, int'(val2), int'(vv2), int'(st2), int'(b2), int'(d2), int'(o2));
        end
    end

    // Returns 1 time unit after the edge E0 that sampled start.
    task automatic do_start(input int i);
        @(negedge clk);
        start_r[i] = 1'b1;
        @(posedge clk);
        #1;
        start_r[i] = 1'b0;
    endtask

    initial begin
        int exp_val [8];
        int busy_cnt, dcnt, rise2, nrise;
        logic prev_b;
        exp_val = '{0, 1, 3, 9, 27, 81, 243, 217};
        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0;
            abort_r[i] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_value", val0, 0); chk("rst_busy", b0, 0); chk("rst_valid", vv0, 0);
        chk("rst_step", st0, 0); chk("rst_done", d0, 0); chk("rst_ovf", o0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        chk_en = 1'b1;

        // Full default run.
        do_start(0);
        chk("t1_value_e0", val0, 0); chk("t1_valid_e0", vv0, 1); chk("t1_busy_e0", b0, 1);
        for (int k = 1; k <= 7; k++) begin
            repeat (100) @(posedge clk);
            #1;
            chk($sformatf("t1_value_k%0d", k), val0, exp_val[k]);
            chk($sformatf("t1_valid_k%0d", k), vv0, 1);
            chk($sformatf("t1_step_k%0d", k), st0, (k > 1) ? k - 1 : 0);
            chk($sformatf("t1_ovf_k%0d", k), o0, (k == 7) ? 1 : 0);
        end
        repeat (99) @(posedge clk);
        #1 chk("t1_done_early", d0, 0);
        @(posedge clk);
        #1 chk("t1_done", d0, 1); chk("t1_busy_end", b0, 0);
        @(posedge clk);
        #1 chk("t1_done_width", d0, 0); chk("t1_value_hold", val0, 217);

        // INTERVAL=1, STEPS=2.
        do_start(1);
        busy_cnt = int'(b1);
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            #1;
            busy_cnt += int'(b1);
            if (n == 1) chk("t2_value1", val1, 1);
            if (n == 2) chk("t2_value2", val1, 3);
            if (n == 3) begin chk("t2_value3", val1, 9); chk("t2_step", st1, 2); end
            if (n == 4) chk("t2_done", d1, 1);
        end
        chk("t2_busy_cycles", busy_cnt, 4);

        // Start held high: back-to-back runs, each restart one cycle after DONE.
        @(negedge clk) start_r[1] = 1'b1;
        prev_b = 1'b0; dcnt = 0; rise2 = -1; nrise = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (b1 && !prev_b) begin
                nrise++;
                if (nrise == 2) rise2 = n;
            end
            dcnt += int'(d1);
            prev_b = b1;
        end
        chk("t3_restart_pos", rise2, 6);
        chk("t3_done_count", dcnt, 3);
        @(negedge clk) start_r[1] = 1'b0;
        repeat (10) @(posedge clk);

        // Abort after the first multiply.
        do_start(0);
        repeat (249) @(posedge clk);
        #1 abort_r[0] = 1'b1;
        @(posedge clk);
        #1 abort_r[0] = 1'b0;
        chk("t4_busy", b0, 0); chk("t4_value", val0, 3); chk("t4_step", st0, 1);
        dcnt = 0;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1 dcnt += int'(vv0) + int'(d0);
        end
        chk("t4_quiet", dcnt, 0);
        chk("t4_value_hold", val0, 3);

        // Asynchronous reset mid-run.
        do_start(0);
        repeat (350) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_value", val0, 0); chk("t5_busy", b0, 0); chk("t5_step", st0, 0);
        chk("t5_valid", vv0, 0); chk("t5_done", d0, 0); chk("t5_ovf", o0, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("t5_idle_busy", b0, 0); chk("t5_idle_value", val0, 0);

        // STEPS=4: no overflow.
        do_start(2);
        repeat (599) @(posedge clk);
        #1 chk("t6_done_early", d2, 0);
        @(posedge clk);
        #1;
        chk("t6_done", d2, 1); chk("t6_value", val2, 81);
        chk("t6_step", st2, 4); chk("t6_ovf", o2, 0);

        // Random traffic on all three configurations, one asynchronous reset.
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                start_r[i] = ($urandom_range(0, 19) == 0);
                abort_r[i] = ($urandom_range(0, (i == 1) ? 29 : 399) == 0);
            end
            if (c == 2500) begin
                #3 rst_n = 1'b0;
                @(negedge clk) rst_n = 1'b1;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0;
            abort_r[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
